// File: rtl/text_console_writer.sv
// Writer side of the LC3 text display: clears text RAM, applies character/control codes at the cursor,
// and handles row overflow. Build option CONSOLE_SCROLL_EN: scroll up on overflow (else wrap and clear row 0).
module text_console_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    char_valid,
  input  logic [7:0]              char_data,
  output logic                    char_ready,
  output logic                    ram_we,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [7:0]              ram_wdata,
  input  logic [7:0]              ram_rdata,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic [$clog2(ROWS)-1:0] cursor_row,
  output logic                    busy
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int NW    = ADDR_W + 1;
  localparam int CELLS = COLS * ROWS;
  localparam logic [7:0] SPACE = 8'h20;
`ifdef CONSOLE_SCROLL_EN
  localparam int SCROLL_CELLS = (ROWS - 1) * COLS;
  localparam int FILL_BASE    = SCROLL_CELLS;
  localparam logic [RW-1:0] OVF_ROW = RW'(ROWS - 1);
`else
  localparam int FILL_BASE    = 0;
  localparam logic [RW-1:0] OVF_ROW = '0;
`endif

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_WRITE,
    S_FILL
`ifdef CONSOLE_SCROLL_EN
    , S_SCROLL_RD,
    S_SCROLL_WR
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [NW-1:0]   cnt, cnt_nxt;
  logic [CW-1:0]   col_nxt;
  logic [RW-1:0]   row_nxt;
  logic [CW-1:0]   col_p1, col_p1_nxt;
  logic [RW-1:0]   row_p1, row_p1_nxt;
  logic            ovf_p1, ovf_p1_nxt;
  logic            we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]      wdata_q, wdata_nxt;
  logic            ready_nxt;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return ADDR_W'(int'(r) * COLS + int'(c));
  endfunction

  // Returns {overflow, next row}; an overflowing row parks at OVF_ROW.
  function automatic logic [RW:0] row_step(input logic [RW-1:0] r);
    if (int'(r) == ROWS - 1) return {1'b1, OVF_ROW};
    return {1'b0, r + 1'b1};
  endfunction

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    col_nxt    = cursor_col;
    row_nxt    = cursor_row;
    col_p1_nxt = col_p1;
    row_p1_nxt = row_p1;
    ovf_p1_nxt = ovf_p1;
    we_nxt     = 1'b0;
    addr_nxt   = ram_addr;
    wdata_nxt  = wdata_q;
    ready_nxt  = 1'b0;
    case (state)
      S_CLEAR: begin
        if (cnt == NW'(CELLS)) begin
          state_nxt = S_IDLE;
          ready_nxt = 1'b1;
          col_nxt   = '0;
          row_nxt   = '0;
        end else begin
          we_nxt    = 1'b1;
          addr_nxt  = ADDR_W'(cnt);
          wdata_nxt = SPACE;
          cnt_nxt   = cnt + 1'b1;
        end
      end
      S_IDLE: begin
        ready_nxt = 1'b1;
        // Acceptance stage: decode the code and precompute the cursor applied after the write cycle.
        if (char_valid && char_ready) begin
          ready_nxt  = 1'b0;
          state_nxt  = S_WRITE;
          col_p1_nxt = cursor_col;
          row_p1_nxt = cursor_row;
          ovf_p1_nxt = 1'b0;
          if (char_data >= 8'h20 && char_data <= 8'h7E) begin
            we_nxt    = 1'b1;
            addr_nxt  = cell_addr(cursor_row, cursor_col);
            wdata_nxt = char_data;
            if (int'(cursor_col) == COLS - 1) begin
              col_p1_nxt = '0;
              {ovf_p1_nxt, row_p1_nxt} = row_step(cursor_row);
            end else begin
              col_p1_nxt = cursor_col + 1'b1;
            end
          end else if (char_data == 8'h0A) begin
            col_p1_nxt = '0;
            {ovf_p1_nxt, row_p1_nxt} = row_step(cursor_row);
          end else if (char_data == 8'h0D) begin
            col_p1_nxt = '0;
          end else if (char_data == 8'h08 && cursor_col != '0) begin
            col_p1_nxt = cursor_col - 1'b1;
            we_nxt     = 1'b1;
            addr_nxt   = cell_addr(cursor_row, cursor_col - 1'b1);
            wdata_nxt  = SPACE;
          end
        end
      end
      // Write stage: commit the cursor, then resume or handle the overflow.
      S_WRITE: begin
        col_nxt = col_p1;
        row_nxt = row_p1;
        if (ovf_p1) begin
          cnt_nxt = '0;
`ifdef CONSOLE_SCROLL_EN
          state_nxt = S_SCROLL_RD;
          addr_nxt  = ADDR_W'(COLS);
`else
          state_nxt = S_FILL;
          we_nxt    = 1'b1;
          addr_nxt  = ADDR_W'(FILL_BASE);
          wdata_nxt = SPACE;
`endif
        end else begin
          state_nxt = S_IDLE;
          ready_nxt = 1'b1;
        end
      end
`ifdef CONSOLE_SCROLL_EN
      S_SCROLL_RD: begin
        state_nxt = S_SCROLL_WR;
        we_nxt    = 1'b1;
        addr_nxt  = ADDR_W'(cnt);
      end
      S_SCROLL_WR: begin
        if (cnt == NW'(SCROLL_CELLS - 1)) begin
          state_nxt = S_FILL;
          cnt_nxt   = '0;
          we_nxt    = 1'b1;
          addr_nxt  = ADDR_W'(FILL_BASE);
          wdata_nxt = SPACE;
        end else begin
          state_nxt = S_SCROLL_RD;
          cnt_nxt   = cnt + 1'b1;
          addr_nxt  = ADDR_W'(cnt + NW'(COLS + 1));
        end
      end
`endif
      S_FILL: begin
        if (cnt == NW'(COLS - 1)) begin
          state_nxt = S_IDLE;
          ready_nxt = 1'b1;
        end else begin
          cnt_nxt  = cnt + 1'b1;
          we_nxt   = 1'b1;
          addr_nxt = ADDR_W'(cnt + NW'(FILL_BASE + 1));
        end
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_CLEAR;
      cnt        <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      col_p1     <= '0;
      row_p1     <= '0;
      ovf_p1     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      wdata_q    <= SPACE;
      char_ready <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cursor_col <= col_nxt;
      cursor_row <= row_nxt;
      col_p1     <= col_p1_nxt;
      row_p1     <= row_p1_nxt;
      ovf_p1     <= ovf_p1_nxt;
      ram_we     <= we_nxt;
      ram_addr   <= addr_nxt;
      wdata_q    <= wdata_nxt;
      char_ready <= ready_nxt;
      busy       <= !ready_nxt;
    end
  end

`ifdef CONSOLE_SCROLL_EN
  // Read data lands in the write cycle, so the copy is forwarded straight from the RAM port.
  assign ram_wdata = (state == S_SCROLL_WR) ? ram_rdata : wdata_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
  assign ram_wdata    = wdata_q;
`endif

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: default 80x30 instance plus a 4x3 instance, each with a text RAM model.
module tb_text_console_writer;
  localparam int AC = 80, AR = 30, AW = 12;
  localparam int BC = 4,  BR = 3,  BW = 4;
  localparam int LIM = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, val;
  logic [7:0] dat;
  bit sel;
  logic val_a, val_b, rdy_a, rdy_b, we_a, we_b, busy_a, busy_b;
  logic [AW-1:0] addr_a;
  logic [BW-1:0] addr_b;
  logic [7:0] wd_a, wd_b, rd_a, rd_b;
  logic [6:0] col_a;
  logic [4:0] row_a;
  logic [1:0] col_b, row_b;

  assign val_a = val && !sel;
  assign val_b = val && sel;

  text_console_writer dut_a (
    .clk(clk), .rst(rst_a), .char_valid(val_a), .char_data(dat), .char_ready(rdy_a),
    .ram_we(we_a), .ram_addr(addr_a), .ram_wdata(wd_a), .ram_rdata(rd_a),
    .cursor_col(col_a), .cursor_row(row_a), .busy(busy_a));

  text_console_writer #(.COLS(BC), .ROWS(BR), .ADDR_W(BW)) dut_b (
    .clk(clk), .rst(rst_b), .char_valid(val_b), .char_data(dat), .char_ready(rdy_b),
    .ram_we(we_b), .ram_addr(addr_b), .ram_wdata(wd_b), .ram_rdata(rd_b),
    .cursor_col(col_b), .cursor_row(row_b), .busy(busy_b));

  logic [7:0] mem_a [0:(1<<AW)-1];
  logic [7:0] mem_b [0:(1<<BW)-1];
  always @(posedge clk) begin
    if (we_a === 1'b1) mem_a[addr_a] <= wd_a;
    rd_a <= mem_a[addr_a];
    if (we_b === 1'b1) mem_b[addr_b] <= wd_b;
    rd_b <= mem_b[addr_b];
  end

  logic rdy_s, we_s, busy_s;
  logic [31:0] addr_s, wd_s, col_s, row_s;
  assign rdy_s  = sel ? rdy_b  : rdy_a;
  assign we_s   = sel ? we_b   : we_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign addr_s = sel ? 32'(addr_b) : 32'(addr_a);
  assign wd_s   = sel ? 32'(wd_b)   : 32'(wd_a);
  assign col_s  = sel ? 32'(col_b)  : 32'(col_a);
  assign row_s  = sel ? 32'(row_b)  : 32'(row_a);

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] memrd(input int i);
    if (sel) return mem_b[i];
    return mem_a[i];
  endfunction

  // Reference screen: plain character grid updated by the console rules.
  logic [7:0] scr [0:AR-1][0:AC-1];
  int mc, mr;

  task automatic model_init(input int cols, input int rows);
    for (int r = 0; r < rows; r++) for (int c = 0; c < cols; c++) scr[r][c] = 8'h20;
    mc = 0; mr = 0;
  endtask

  task automatic model_step(input logic [7:0] c, input int cols, input int rows, output int extra);
    bit adv = 1'b0;
    extra = 0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      scr[mr][mc] = c; mc++;
      if (mc == cols) begin mc = 0; adv = 1'b1; end
    end else if (c == 8'h0A) begin
      mc = 0; adv = 1'b1;
    end else if (c == 8'h0D) begin
      mc = 0;
    end else if (c == 8'h08 && mc > 0) begin
      mc--; scr[mr][mc] = 8'h20;
    end
    if (adv) begin
      if (mr == rows - 1) begin
`ifdef CONSOLE_SCROLL_EN
        for (int r = 0; r < rows - 1; r++) for (int k = 0; k < cols; k++) scr[r][k] = scr[r+1][k];
        for (int k = 0; k < cols; k++) scr[rows-1][k] = 8'h20;
        extra = 2 * (rows - 1) * cols + cols;
`else
        mr = 0;
        for (int k = 0; k < cols; k++) scr[0][k] = 8'h20;
        extra = cols;
`endif
      end else begin
        mr++;
      end
    end
  endtask

  task automatic screen_check(input string name, input int cols, input int rows);
    int bad = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        if (memrd(r * cols + c) !== scr[r][c]) bad++;
    check(name, bad, 0);
  endtask

  // Follows the clear after reset release; cycle 1 is the first cycle after deassertion.
  task automatic clear_run(input string tag, input int cells);
    int first = -1, nw = 0, bad = 0, rc = -1;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (rdy_s === 1'b1) begin rc = k; break; end
      if (we_s === 1'b1) begin
        if (first < 0) first = k;
        if (addr_s !== 32'(nw) || wd_s !== 32'h20) bad++;
        nw++;
      end
    end
    check({tag, "_clr_first_cycle"}, first, 1);
    check({tag, "_clr_writes"}, nw, cells);
    check({tag, "_clr_bad_writes"}, bad, 0);
    check({tag, "_clr_ready_cycle"}, rc, cells + 1);
    check({tag, "_clr_col"}, col_s, 0);
    check({tag, "_clr_row"}, row_s, 0);
  endtask

  task automatic send(input logic [7:0] c, output int nw, output logic [31:0] waddr,
                      output logic [31:0] wdat, output int low);
    int t = 0;
    while (rdy_s !== 1'b1 && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) check("ready_timeout", 0, 1);
    val = 1'b1; dat = c;
    @(negedge clk);
    val = 1'b0;
    nw = 0; waddr = '1; wdat = '1; low = 0;
    while (rdy_s !== 1'b1 && low < LIM) begin
      if (we_s === 1'b1) begin
        if (nw == 0) begin waddr = addr_s; wdat = wd_s; end
        nw++;
      end
      low++;
      @(negedge clk);
    end
    if (low >= LIM) check("busy_timeout", 0, 1);
  endtask

  task automatic run_random(input string tag, input int n, input int cols, input int rows);
    for (int i = 0; i < n; i++) begin
      logic [7:0] c;
      int r, extra, nw, low;
      logic [31:0] wa, wdv;
      r = $urandom_range(0, 99);
      if (r < 68)      c = 8'($urandom_range(32, 126));
      else if (r < 86) c = 8'h0A;
      else if (r < 90) c = 8'h0D;
      else if (r < 96) c = 8'h08;
      else if (r[0])   c = 8'($urandom_range(0, 31));
      else             c = 8'($urandom_range(127, 255));
      model_step(c, cols, rows, extra);
      send(c, nw, wa, wdv, low);
      check({tag, "_col"}, col_s, mc);
      check({tag, "_row"}, row_s, mr);
      check({tag, "_busy_cycles"}, low, 1 + extra);
    end
  endtask

  typedef struct {
    logic [7:0]  c;
    int          nw;
    logic [31:0] waddr;
    logic [31:0] wdat;
    int          col;
    int          row;
    int          low;
  } vec_t;

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [10];
    int nw, low, n, bad, extra;
    logic [31:0] wa, wdv;
    string exp_s;
    int exp_row, exp_low;

    tbl[0] = '{8'h41, 1, 0,   32'h41, 1, 0, 1};
    tbl[1] = '{8'h42, 1, 1,   32'h42, 2, 0, 1};
    tbl[2] = '{8'h08, 1, 1,   32'h20, 1, 0, 1};
    tbl[3] = '{8'h0D, 0, '1,  '1,     0, 0, 1};
    tbl[4] = '{8'h0A, 0, '1,  '1,     0, 1, 1};
    tbl[5] = '{8'h08, 0, '1,  '1,     0, 1, 1};
    tbl[6] = '{8'h07, 0, '1,  '1,     0, 1, 1};
    tbl[7] = '{8'h7E, 1, 80,  32'h7E, 1, 1, 1};
    tbl[8] = '{8'h7F, 0, '1,  '1,     1, 1, 1};
    tbl[9] = '{8'h20, 1, 81,  32'h20, 2, 1, 1};

    rst_a = 1'b1; rst_b = 1'b1; val = 1'b0; dat = 8'h00; sel = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      check("rst_ready", rdy_s, 0);
      check("rst_busy", busy_s, 1);
      check("rst_we", we_s, 0);
      check("rst_addr", addr_s, 0);
      check("rst_wdata", wd_s, 32'h20);
      check("rst_col", col_s, 0);
      check("rst_row", row_s, 0);
    end

    sel = 1'b0;
    rst_a = 1'b0;
    clear_run("a", AC * AR);

    for (int i = 0; i < 10; i++) begin
      send(tbl[i].c, nw, wa, wdv, low);
      check($sformatf("vec%0d_writes", i), nw, tbl[i].nw);
      check($sformatf("vec%0d_addr", i), wa, tbl[i].waddr);
      check($sformatf("vec%0d_wdata", i), wdv, tbl[i].wdat);
      check($sformatf("vec%0d_col", i), col_s, tbl[i].col);
      check($sformatf("vec%0d_row", i), row_s, tbl[i].row);
      check($sformatf("vec%0d_busy_cycles", i), low, tbl[i].low);
    end
    check("ram_after_AB_bs_0", memrd(0), 8'h41);
    check("ram_after_AB_bs_1", memrd(1), 8'h20);

    // Valid held into the busy cycle with a different code must be ignored.
    val = 1'b1; dat = 8'h51;
    @(negedge clk);
    dat = 8'h5A;
    @(negedge clk);
    val = 1'b0;
    nw = 0;
    for (int k = 0; k < 4; k++) begin
      if (we_s === 1'b1) nw++;
      @(negedge clk);
    end
    check("ignore_no_extra_write", nw, 0);
    check("ignore_col", col_s, 3);
    check("ignore_ram_q", memrd(82), 8'h51);
    check("ignore_ram_next", memrd(83), 8'h20);

    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    clear_run("a2", AC * AR);
    model_init(AC, AR);
    run_random("rnd_a", 300, AC, AR);
    screen_check("rnd_a_screen", AC, AR);

    sel = 1'b1;
    rst_b = 1'b0;
    clear_run("b", BC * BR);
    model_init(BC, BR);
    for (int i = 0; i < 12; i++) begin
      model_step(8'(8'h41 + i), BC, BR, extra);
      send(8'(8'h41 + i), nw, wa, wdv, low);
    end
`ifdef CONSOLE_SCROLL_EN
    exp_s = "EFGHIJKL    "; exp_row = 2; exp_low = 1 + 20;
`else
    exp_s = "    EFGHIJKL"; exp_row = 0; exp_low = 1 + 4;
`endif
    bad = 0;
    for (int i = 0; i < 12; i++) if (mem_b[i] !== exp_s[i]) bad++;
    check("b12_ram_cells_wrong", bad, 0);
    check("b12_col", col_s, 0);
    check("b12_row", row_s, exp_row);
    check("b12_overflow_busy_cycles", low, exp_low);
    screen_check("b12_screen_model", BC, BR);

    // Reset in the middle of overflow handling.
    n = BR - int'(row_s);
    for (int i = 0; i < n - 1; i++) send(8'h0A, nw, wa, wdv, low);
    val = 1'b1; dat = 8'h0A;
    @(negedge clk);
    val = 1'b0;
    repeat (2) @(negedge clk);
    check("midovf_busy", busy_s, 1);
    check("midovf_ready", rdy_s, 0);
    rst_b = 1'b1;
    #1;
    check("midovf_rst_ready", rdy_s, 0);
    check("midovf_rst_we", we_s, 0);
    check("midovf_rst_addr", addr_s, 0);
    check("midovf_rst_col", col_s, 0);
    check("midovf_rst_row", row_s, 0);
    @(negedge clk);
    rst_b = 1'b0;
    clear_run("b2", BC * BR);
    model_init(BC, BR);
    screen_check("b2_screen_clear", BC, BR);

    run_random("rnd_b", 150, BC, BR);
    screen_check("rnd_b_screen", BC, BR);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
